bira_alloc: RTL and testbench

BIRA_ALLOC -- requirements
Module: bira_alloc

---
 rtl/bira_alloc.sv | 221 ++++++++++++++++++++++
 tb/tb_bira_alloc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bira_alloc.sv
// Built-in redundancy allocator: collects BIST faults into a table, then assigns shared spare rows/cols.
// Optional on-the-fly must-repair during collection is enabled by defining BIRA_MUST_REPAIR_EN.
module bira_alloc #(
  parameter int SPARE_ROWS  = 2,
  parameter int SPARE_COLS  = 2,
  parameter int TABLE_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    test,
  input  logic                    test_end,
  input  logic                    fault_detect,
  input  logic [1:0]              fault_bank,
  input  logic [9:0]              fault_row,
  input  logic [9:0]              fault_col,
  input  logic [7:0]              fault_col_flag,
  output logic                    repair_end,
  output logic                    repair_fail,
  output logic [SPARE_ROWS-1:0]   srow_valid,
  output logic [12*SPARE_ROWS-1:0] srow_addr,
  output logic [SPARE_COLS-1:0]   scol_valid,
  output logic [12*SPARE_COLS-1:0] scol_addr
);

  localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam int SR_W  = (SPARE_ROWS  > 1) ? $clog2(SPARE_ROWS)  : 1;
  localparam int SC_W  = (SPARE_COLS  > 1) ? $clog2(SPARE_COLS)  : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, FINAL, DONE} state_t;

  state_t             state, state_next;
  logic               drain_cnt;
  logic [IDX_W-1:0]   scan_idx;

  logic [TABLE_DEPTH-1:0] tbl_valid;
  logic [1:0]         tbl_bank [TABLE_DEPTH];
  logic [9:0]         tbl_row  [TABLE_DEPTH];
  logic [9:0]         tbl_col  [TABLE_DEPTH];

  // Per-bit fail positions carry no weight in word-granular allocation.
  logic unused_col_flag;
  assign unused_col_flag = ^fault_col_flag;

  // Lookup results for the incoming fault and for the entry under the FINAL scan pointer.
  logic               f_hit, f_dup, e_hit, tbl_full, has_free_row, has_free_col;
  logic [IDX_W-1:0]   free_idx;
  logic [SR_W-1:0]    free_row_idx;
  logic [SC_W-1:0]    free_col_idx;
  logic [1:0]         sel_bank;
  logic [9:0]         sel_row, sel_col;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    f_hit        = 1'b0;
    e_hit        = 1'b0;
    f_dup        = 1'b0;
    sel_bank     = tbl_bank[scan_idx];
    sel_row      = tbl_row[scan_idx];
    sel_col      = tbl_col[scan_idx];
    free_idx     = '0;
    free_row_idx = '0;
    free_col_idx = '0;
    for (int i = 0; i < SPARE_ROWS; i++) begin
      if (srow_valid[i]) begin
        if (srow_addr[12*i +: 12] == {fault_bank, fault_row}) f_hit = 1'b1;
        if (srow_addr[12*i +: 12] == {sel_bank, sel_row})     e_hit = 1'b1;
      end
    end
    for (int i = 0; i < SPARE_COLS; i++) begin
      if (scol_valid[i]) begin
        if (scol_addr[12*i +: 12] == {fault_bank, fault_col}) f_hit = 1'b1;
        if (scol_addr[12*i +: 12] == {sel_bank, sel_col})     e_hit = 1'b1;
      end
    end
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (tbl_valid[i] && tbl_bank[i] == fault_bank && tbl_row[i] == fault_row &&
          tbl_col[i] == fault_col)
        f_dup = 1'b1;
    end
    // Descending scans so the lowest free index wins.
    for (int i = TABLE_DEPTH-1; i >= 0; i--) if (!tbl_valid[i]) free_idx = IDX_W'(i);
    for (int i = SPARE_ROWS-1; i >= 0; i--) if (!srow_valid[i]) free_row_idx = SR_W'(i);
    for (int i = SPARE_COLS-1; i >= 0; i--) if (!scol_valid[i]) free_col_idx = SC_W'(i);
    tbl_full     = &tbl_valid;
    has_free_row = ~&srow_valid;
    has_free_col = ~&scol_valid;
  end

`ifdef BIRA_MUST_REPAIR_EN
  // Faults sharing the new fault's line (including itself) versus spares left on the other axis.
  int row_cnt, col_cnt, free_rows, free_cols;
  always_comb begin
    row_cnt   = 1;
    col_cnt   = 1;
    free_rows = 0;
    free_cols = 0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (tbl_valid[i] && tbl_bank[i] == fault_bank && tbl_row[i] == fault_row) row_cnt++;
      if (tbl_valid[i] && tbl_bank[i] == fault_bank && tbl_col[i] == fault_col) col_cnt++;
    end
    for (int i = 0; i < SPARE_ROWS; i++) if (!srow_valid[i]) free_rows++;
    for (int i = 0; i < SPARE_COLS; i++) if (!scol_valid[i]) free_cols++;
  end
`endif

  logic       start, store, alloc_row, alloc_col, set_fail;
  logic [1:0] alloc_bank;
  logic [9:0] alloc_row_a, alloc_col_a;

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    store       = 1'b0;
    alloc_row   = 1'b0;
    alloc_col   = 1'b0;
    set_fail    = 1'b0;
    alloc_bank  = fault_bank;
    alloc_row_a = fault_row;
    alloc_col_a = fault_col;
    case (state)
      IDLE: if (test) begin
        state_next = COLLECT;
        start      = 1'b1;
      end
      COLLECT, DRAIN: begin
        if (fault_detect && !f_hit && !f_dup) begin
`ifdef BIRA_MUST_REPAIR_EN
          if (row_cnt > free_cols) begin
            if (has_free_row) alloc_row = 1'b1;
            else              set_fail  = 1'b1;
          end else if (col_cnt > free_rows) begin
            if (has_free_col) alloc_col = 1'b1;
            else              set_fail  = 1'b1;
          end else if (tbl_full) set_fail = 1'b1;
          else                   store    = 1'b1;
`else
          if (tbl_full) set_fail = 1'b1;
          else          store    = 1'b1;
`endif
        end
        if (state == COLLECT) begin
          if (test_end) state_next = DRAIN;
        end else if (drain_cnt) begin
          state_next = FINAL;
        end
        if (set_fail) state_next = DONE;
      end
      FINAL: begin
        alloc_bank  = sel_bank;
        alloc_row_a = sel_row;
        alloc_col_a = sel_col;
        if (tbl_valid[scan_idx] && !e_hit) begin
          if (has_free_row)      alloc_row = 1'b1;
          else if (has_free_col) alloc_col = 1'b1;
          else                   set_fail  = 1'b1;
        end
        if (set_fail || scan_idx == IDX_W'(TABLE_DEPTH-1)) state_next = DONE;
      end
      DONE: if (!test) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      scan_idx  <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN);
      scan_idx  <= (state == FINAL) ? scan_idx + IDX_W'(1) : '0;
    end
  end

  // NOTE: only table valid bits are reset; entry payload is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_valid   <= '0;
      srow_valid  <= '0;
      srow_addr   <= '0;
      scol_valid  <= '0;
      scol_addr   <= '0;
      repair_fail <= 1'b0;
    end else begin
      if (start) begin
        tbl_valid   <= '0;
        srow_valid  <= '0;
        srow_addr   <= '0;
        scol_valid  <= '0;
        scol_addr   <= '0;
        repair_fail <= 1'b0;
      end
      if (store) begin
        tbl_valid[free_idx] <= 1'b1;
        tbl_bank[free_idx]  <= fault_bank;
        tbl_row[free_idx]   <= fault_row;
        tbl_col[free_idx]   <= fault_col;
      end
      if (alloc_row) begin
        srow_valid[free_row_idx]          <= 1'b1;
        srow_addr[12*free_row_idx +: 12]  <= {alloc_bank, alloc_row_a};
      end
      if (alloc_col) begin
        scol_valid[free_col_idx]          <= 1'b1;
        scol_addr[12*free_col_idx +: 12]  <= {alloc_bank, alloc_col_a};
      end
      // A new spare retires every entry on its line in the same cycle.
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        if ((alloc_row && tbl_bank[i] == alloc_bank && tbl_row[i] == alloc_row_a) ||
            (alloc_col && tbl_bank[i] == alloc_bank && tbl_col[i] == alloc_col_a))
          tbl_valid[i] <= 1'b0;
      end
      if (set_fail) repair_fail <= 1'b1;
    end
  end

  assign repair_end = (state == DONE);

endmodule

// File: tb/tb_bira_alloc.sv
// Directed self-checking bench for bira_alloc (default pool: 2 spare rows, 2 spare cols, 8 entries).
// The must-repair scenario runs only when BIRA_MUST_REPAIR_EN is defined.
module tb_bira_alloc;

  logic        clk, rst, test, test_end, fault_detect;
  logic [1:0]  fault_bank;
  logic [9:0]  fault_row, fault_col;
  logic [7:0]  fault_col_flag;
  logic        repair_end, repair_fail;
  logic [1:0]  srow_valid, scol_valid;
  logic [23:0] srow_addr, scol_addr;

  integer checks = 0;
  integer errors = 0;

  bira_alloc dut (
    .clk(clk), .rst(rst), .test(test), .test_end(test_end),
    .fault_detect(fault_detect), .fault_bank(fault_bank), .fault_row(fault_row),
    .fault_col(fault_col), .fault_col_flag(fault_col_flag),
    .repair_end(repair_end), .repair_fail(repair_fail),
    .srow_valid(srow_valid), .srow_addr(srow_addr),
    .scol_valid(scol_valid), .scol_addr(scol_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    test = 1'b1;
    step();
  endtask

  task automatic send(input logic [1:0] b, input logic [9:0] r, input logic [9:0] c);
    fault_detect = 1'b1;
    fault_bank   = b;
    fault_row    = r;
    fault_col    = c;
    step();
    fault_detect = 1'b0;
  endtask

  task automatic end_run();
    test     = 1'b0;
    test_end = 1'b0;
    step();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (repair_end !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (repair_end !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: repair_end=%b expected 1", name, repair_end);
    end
  endtask

  task automatic finish_bist(input string name);
    test_end = 1'b1;
    step();
    wait_done(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; test = 1'b0;
    step(); step();
    checks++;
    if (repair_end !== 1'b0) begin errors++; $display("FAIL reset_end: got %b expected 0", repair_end); end
    checks++;
    if (repair_fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b expected 0", repair_fail); end
    checks++;
    if ({srow_valid, scol_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", {srow_valid, scol_valid});
    end
    checks++;
    if ({srow_addr, scol_addr} !== 48'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", {srow_addr, scol_addr});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_no_faults();
    start_run();
    test_end = 1'b1;
    step();
    repeat (9) step();
    checks++;
    if (repair_end !== 1'b0) begin errors++; $display("FAIL latency_early: repair_end=%b expected 0", repair_end); end
    step();
    checks++;
    if (repair_end !== 1'b1) begin errors++; $display("FAIL latency_done: repair_end=%b expected 1", repair_end); end
    checks++;
    if ({repair_fail, srow_valid, scol_valid} !== 5'b0) begin
      errors++; $display("FAIL nofault_result: got %b expected 00000", {repair_fail, srow_valid, scol_valid});
    end
    end_run();
    checks++;
    if (repair_end !== 1'b0) begin errors++; $display("FAIL done_to_idle: repair_end=%b expected 0", repair_end); end
  endtask

  task automatic test_single_fault();
    start_run();
    send(2'd1, 10'd5, 10'd16);
    finish_bist("single");
    checks++;
    if (srow_valid !== 2'b01) begin errors++; $display("FAIL single_srow_valid: got %b expected 01", srow_valid); end
    checks++;
    if (srow_addr[11:0] !== 12'h405) begin errors++; $display("FAIL single_srow_addr: got %h expected 405", srow_addr[11:0]); end
    checks++;
    if ({repair_fail, scol_valid} !== 3'b0) begin
      errors++; $display("FAIL single_misc: got %b expected 000", {repair_fail, scol_valid});
    end
    end_run();
  endtask

  task automatic test_duplicate();
    start_run();
    send(2'd1, 10'd5, 10'd16);
    send(2'd1, 10'd5, 10'd16);
    send(2'd1, 10'd5, 10'd24);
    finish_bist("dup");
    checks++;
    if ({srow_valid, scol_valid, repair_fail} !== 5'b01000) begin
      errors++; $display("FAIL dup_alloc: got %b expected 01000", {srow_valid, scol_valid, repair_fail});
    end
    checks++;
    if (srow_addr[11:0] !== 12'h405) begin errors++; $display("FAIL dup_addr: got %h expected 405", srow_addr[11:0]); end
    end_run();
    // Twelve copies of one fault must occupy a single entry, never filling the 8-entry table.
    start_run();
    repeat (12) send(2'd3, 10'd100, 10'd200);
    finish_bist("dup12");
    checks++;
    if ({repair_fail, srow_valid} !== 3'b001) begin
      errors++; $display("FAIL dup_no_overflow: got %b expected 001", {repair_fail, srow_valid});
    end
    checks++;
    if (srow_addr[11:0] !== 12'hC64) begin errors++; $display("FAIL dup12_addr: got %h expected c64", srow_addr[11:0]); end
    end_run();
  endtask

  task automatic test_table_full();
    start_run();
    for (int i = 0; i < 8; i++) send(2'd0, 10'(i), 10'(i));
    checks++;
    if (repair_end !== 1'b0) begin errors++; $display("FAIL full_early: repair_end=%b expected 0", repair_end); end
    send(2'd0, 10'd8, 10'd8);
    checks++;
    if ({repair_end, repair_fail} !== 2'b11) begin
      errors++; $display("FAIL full_fail: got %b expected 11", {repair_end, repair_fail});
    end
    checks++;
    if ({srow_valid, scol_valid} !== 4'b0) begin
      errors++; $display("FAIL full_no_alloc: got %b expected 0000", {srow_valid, scol_valid});
    end
    end_run();
    checks++;
    if (repair_fail !== 1'b1) begin errors++; $display("FAIL fail_sticky: got %b expected 1", repair_fail); end
    start_run();
    checks++;
    if (repair_fail !== 1'b0) begin errors++; $display("FAIL fail_cleared: got %b expected 0", repair_fail); end
    finish_bist("after_full");
    end_run();
  endtask

  task automatic test_five_faults();
    logic [23:0] hold_r, hold_c;
    start_run();
    for (int i = 1; i <= 5; i++) send(2'd0, 10'(i), 10'(i));
    finish_bist("five");
    checks++;
    if (repair_fail !== 1'b1) begin errors++; $display("FAIL five_fail: got %b expected 1", repair_fail); end
    checks++;
    if ({srow_valid, scol_valid} !== 4'b1111) begin
      errors++; $display("FAIL five_valid: got %b expected 1111", {srow_valid, scol_valid});
    end
    checks++;
    if (srow_addr !== 24'h002001) begin errors++; $display("FAIL five_srow: got %h expected 002001", srow_addr); end
    checks++;
    if (scol_addr !== 24'h004003) begin errors++; $display("FAIL five_scol: got %h expected 004003", scol_addr); end
    // Faults presented in DONE must not disturb the result.
    hold_r = 24'h002001;
    hold_c = 24'h004003;
    repeat (3) send(2'd2, 10'd9, 10'd9);
    checks++;
    if ({repair_end, srow_addr, scol_addr} !== {1'b1, hold_r, hold_c}) begin
      errors++; $display("FAIL done_hold: got %b %h %h expected 1 %h %h", repair_end, srow_addr, scol_addr, hold_r, hold_c);
    end
    end_run();
  endtask

  task automatic test_drain();
    start_run();
    fault_detect = 1'b1; fault_bank = 2'd0; fault_row = 10'd10; fault_col = 10'd1;
    test_end = 1'b1;
    step();
    fault_detect = 1'b0;
    step();
    send(2'd3, 10'd9, 10'd2);
    send(2'd2, 10'd3, 10'd3);
    wait_done("drain");
    checks++;
    if ({srow_valid, scol_valid, repair_fail} !== 5'b11000) begin
      errors++; $display("FAIL drain_valid: got %b expected 11000", {srow_valid, scol_valid, repair_fail});
    end
    checks++;
    if (srow_addr !== 24'hC0900A) begin errors++; $display("FAIL drain_addr: got %h expected c0900a", srow_addr); end
    end_run();
  endtask

  task automatic test_rst_in_final();
    start_run();
    send(2'd1, 10'd5, 10'd16);
    test_end = 1'b1;
    step();
    step(); step(); step();
    checks++;
    if (srow_valid !== 2'b01) begin errors++; $display("FAIL final_alloc: got %b expected 01", srow_valid); end
    rst = 1'b1; test = 1'b0; test_end = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if ({repair_end, repair_fail, srow_valid, scol_valid, srow_addr, scol_addr} !== 54'h0) begin
      errors++; $display("FAIL midrst_clear: got %b %b %b %b %h %h expected all 0",
        repair_end, repair_fail, srow_valid, scol_valid, srow_addr, scol_addr);
    end
    step(); step();
    checks++;
    if (repair_end !== 1'b0) begin errors++; $display("FAIL midrst_idle: repair_end=%b expected 0", repair_end); end
    start_run();
    finish_bist("after_rst");
    checks++;
    if ({repair_fail, srow_valid, scol_valid} !== 5'b0) begin
      errors++; $display("FAIL midrst_clean: got %b expected 00000", {repair_fail, srow_valid, scol_valid});
    end
    end_run();
  endtask

`ifdef BIRA_MUST_REPAIR_EN
  task automatic test_must_repair();
    start_run();
    send(2'd2, 10'd7, 10'd0);
    send(2'd2, 10'd7, 10'd8);
    checks++;
    if (srow_valid !== 2'b00) begin errors++; $display("FAIL mr_early: got %b expected 00", srow_valid); end
    send(2'd2, 10'd7, 10'd16);
    checks++;
    if (srow_valid !== 2'b01) begin errors++; $display("FAIL mr_alloc: got %b expected 01", srow_valid); end
    checks++;
    if (srow_addr[11:0] !== 12'h807) begin errors++; $display("FAIL mr_addr: got %h expected 807", srow_addr[11:0]); end
    finish_bist("mr");
    checks++;
    if ({srow_valid, scol_valid, repair_fail} !== 5'b01000) begin
      errors++; $display("FAIL mr_final: got %b expected 01000", {srow_valid, scol_valid, repair_fail});
    end
    end_run();
  endtask
`endif

  initial begin
    rst = 1'b1; test = 1'b0; test_end = 1'b0; fault_detect = 1'b0;
    fault_bank = '0; fault_row = '0; fault_col = '0; fault_col_flag = 8'h01;
    test_reset();
    test_no_faults();
    test_single_fault();
    test_duplicate();
    test_table_full();
    test_five_faults();
    test_drain();
    test_rst_in_final();
`ifdef BIRA_MUST_REPAIR_EN
    test_must_repair();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
